// File: rtl/rv32_mod_data_sram.sv
// ---------------------------------------------------------------------------
// rv32_mod_data_sram
//
// Word-organised single-port data memory that terminates the hart's external
// data bus. One access is in flight at a time. Writes are merged per byte
// lane. Reads return the full aligned word; the LSU extracts and sign-extends
// the lanes it needs. A configurable number of wait states separates the
// accept edge from the response. Out-of-range or malformed accesses are
// answered with err instead of ack.
//
// Optional feature macro: RV32_DSRAM_BE_CHECK_EN
//   When defined, only naturally shaped byte-enable patterns are accepted:
//   0001, 0010, 0100, 1000, 0011, 1100 and 1111. Any other nonzero pattern
//   is answered with err.
//   When undefined, any nonzero be is accepted and masked per lane.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words; a power of two, at least 2
//   BASE_ADDR   : byte address of word 0; aligned to DEPTH_WORDS*4
//   WAIT_STATES : extra cycles between accept and response, 0..15
//
// Ports
//   clk   : clock
//   reset : asynchronous, active-high reset
//   req   : one-cycle request strobe from the LSU
//   wr    : 1 = write, 0 = read; sampled with req
//   be    : byte enables; bit n selects data[8n+7:8n]
//   addr  : byte address; addr[1:0] are not used to select the word
//   wdata : write data for all lanes; only enabled lanes are stored
//   rdata : read word; valid only while ack is high on a read, 0 otherwise
//   ack   : one-cycle completion pulse
//   err   : one-cycle error pulse; never high together with ack
// ---------------------------------------------------------------------------
module rv32_mod_data_sram #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [3:0]  be,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err
);

    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    // One past the last valid byte address. It is computed in 33 bits so that
    // a window ending exactly at 4 GiB does not wrap to zero.
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]  state_reg;
    logic [3:0]  cnt_reg;
    logic        ack_reg;
    logic        err_reg;
    logic        rd_valid_reg;

    // Request captured at the accept edge. This is only needed when the
    // response is deferred by wait states.
    logic        lat_wr_reg;
    logic [3:0]  lat_be_reg;
    logic [31:0] lat_addr_reg;
    logic [31:0] lat_wdata_reg;

    // The access that commits on this edge.
    logic        acc_wr;
    logic [3:0]  acc_be;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        commit;

    logic        in_range;
    logic        be_ok;
    logic        acc_ok;
    logic        mem_we;
    logic        mem_re;
    logic [IDX_W-1:0] acc_idx;
    logic [31:0] rd_word;

    // ---------------------------------------------------------------------
    // Commit source. With no wait states the access commits on the accept
    // edge straight from the bus. Otherwise it commits from the latched copy
    // when the wait counter expires.
    // ---------------------------------------------------------------------
    generate
        if (WAIT_STATES == 0) begin : g_direct
            assign acc_wr    = wr;
            assign acc_be    = be;
            assign acc_addr  = addr;
            assign acc_wdata = wdata;
            assign commit    = req;
        end else begin : g_deferred
            assign acc_wr    = lat_wr_reg;
            assign acc_be    = lat_be_reg;
            assign acc_addr  = lat_addr_reg;
            assign acc_wdata = lat_wdata_reg;
            assign commit    = (state_reg == BUSY) && (cnt_reg == 4'd0);
        end
    endgenerate

    // Unsigned compare against the window. BASE_ADDR is aligned to the window
    // size, so the word index is simply the address bits above the byte offset.
    assign in_range = ({1'b0, acc_addr} >= {1'b0, BASE_ADDR}) &&
                      ({1'b0, acc_addr} <  LIMIT);
    assign acc_idx  = acc_addr[IDX_W+1:2];

`ifdef RV32_DSRAM_BE_CHECK_EN
    always_comb begin
        be_ok = 1'b0;
        case (acc_be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: be_ok = 1'b1;
            default:                   be_ok = 1'b0;
        endcase
    end
`else
    assign be_ok = (acc_be != 4'b0000);
`endif

    assign acc_ok = in_range && be_ok;
    assign mem_we = commit && acc_ok && acc_wr;
    assign mem_re = commit && acc_ok && !acc_wr;

    // ---------------------------------------------------------------------
    // Control FSM and response registers.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            ack_reg      <= 1'b0;
            err_reg      <= 1'b0;
            rd_valid_reg <= 1'b0;
        end else begin
            ack_reg      <= commit && acc_ok;
            err_reg      <= commit && !acc_ok;
            rd_valid_reg <= mem_re;
            case (state_reg)
                IDLE: begin
                    if (req && (WAIT_STATES != 0)) begin
                        state_reg <= BUSY;
                        cnt_reg   <= 4'(WAIT_STATES - 1);
                    end
                end
                BUSY: begin
                    // Requests arriving here are dropped, not queued.
                    if (cnt_reg == 4'd0) begin
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // The request copy needs no reset. It is only consumed while BUSY, and
    // BUSY is always entered through a capture.
    always_ff @(posedge clk) begin
        if ((state_reg == IDLE) && req) begin
            lat_wr_reg    <= wr;
            lat_be_reg    <= be;
            lat_addr_reg  <= addr;
            lat_wdata_reg <= wdata;
        end
    end

    // ---------------------------------------------------------------------
    // Storage. It is split into one byte-wide array per lane so that each
    // lane has a single writer and the byte merge is a plain per-lane
    // write enable. The read port is registered, so a read word is ready in
    // the same cycle as ack.
    // ---------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];
            logic [7:0] lane_q_reg;

            always_ff @(posedge clk) begin
                if (mem_we && acc_be[gi]) begin
                    mem[acc_idx] <= acc_wdata[8*gi +: 8];
                end
                if (mem_re) begin
                    lane_q_reg <= mem[acc_idx];
                end
            end

            assign rd_word[8*gi +: 8] = lane_q_reg;
        end
    endgenerate

    // The read word is only exposed during a read ack. Otherwise the bus
    // reads as zero.
    assign rdata = rd_valid_reg ? rd_word : 32'h0000_0000;
    assign ack   = ack_reg;
    assign err   = err_reg;

endmodule

// File: tb/tb_rv32_mod_data_sram.sv
// ---------------------------------------------------------------------------
// tb_rv32_mod_data_sram
//
// Four instances of the data SRAM are used, with WAIT_STATES = 0, 1 (the
// default), 2 and 3. Instance k therefore has k wait states. Each driven
// request pushes its expected response and due cycle onto a scoreboard
// queue. A monitor pops the queue whenever an instance raises ack or err.
// Most traffic comes from a vector table. The multi-cycle corners use
// hand-written sequences: back-to-back requests, a request dropped while
// BUSY, and reset during an access.
// ---------------------------------------------------------------------------
module tb_rv32_mod_data_sram;

`ifdef RV32_DSRAM_BE_CHECK_EN
    localparam bit BE_CHK = 1'b1;
`else
    localparam bit BE_CHK = 1'b0;
`endif

    localparam int WS_OF [4] = '{0, 1, 2, 3};

    typedef struct {
        int          inst;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        int          inst;
        int          due;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_s   [4];
    logic        req_s   [4];
    logic        wr_s    [4];
    logic [3:0]  be_s    [4];
    logic [31:0] addr_s  [4];
    logic [31:0] wdata_s [4];
    logic [31:0] rdata_s [4];
    logic        ack_s   [4];
    logic        err_s   [4];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q [$];
    vec_t vecs [32];
    int   nv = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rv32_mod_data_sram #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(rst_s[0]), .req(req_s[0]), .wr(wr_s[0]), .be(be_s[0]),
        .addr(addr_s[0]), .wdata(wdata_s[0]), .rdata(rdata_s[0]), .ack(ack_s[0]), .err(err_s[0]));
    rv32_mod_data_sram u_ws1 (
        .clk(clk), .reset(rst_s[1]), .req(req_s[1]), .wr(wr_s[1]), .be(be_s[1]),
        .addr(addr_s[1]), .wdata(wdata_s[1]), .rdata(rdata_s[1]), .ack(ack_s[1]), .err(err_s[1]));
    rv32_mod_data_sram #(.WAIT_STATES(2)) u_ws2 (
        .clk(clk), .reset(rst_s[2]), .req(req_s[2]), .wr(wr_s[2]), .be(be_s[2]),
        .addr(addr_s[2]), .wdata(wdata_s[2]), .rdata(rdata_s[2]), .ack(ack_s[2]), .err(err_s[2]));
    rv32_mod_data_sram #(.WAIT_STATES(3)) u_ws3 (
        .clk(clk), .reset(rst_s[3]), .req(req_s[3]), .wr(wr_s[3]), .be(be_s[3]),
        .addr(addr_s[3]), .wdata(wdata_s[3]), .rdata(rdata_s[3]), .ack(ack_s[3]), .err(err_s[3]));

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d cyc=%0d actual=%h required=%h", nm, k, cyc, act, exp);
        end
    endtask

    task automatic add(input int k, input logic w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] d, input logic e, input logic [31:0] r);
        vecs[nv] = '{inst: k, wr: w, be: b, addr: a, wdata: d, err: e, rdata: r};
        nv++;
    endtask

    // This task is called just after a falling edge. It drives one request
    // and, if a response is expected, records that response as due in cycle
    // T+1+WS.
    task automatic issue(input int k, input logic w, input logic [3:0] b, input logic [31:0] a,
                         input logic [31:0] d, input logic e, input logic [31:0] r, input bit expect_resp);
        exp_t x;
        req_s[k] = 1'b1; wr_s[k] = w; be_s[k] = b; addr_s[k] = a; wdata_s[k] = d;
        if (expect_resp) begin
            x = '{inst: k, due: cyc + 1 + WS_OF[k], err: e, rdata: r};
            sb_q.push_back(x);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout pending=%0d actual=no_response required=response", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic do_access(input vec_t v);
        @(negedge clk);
        issue(v.inst, v.wr, v.be, v.addr, v.wdata, v.err, v.rdata, 1'b1);
        @(negedge clk);
        req_s[v.inst] = 1'b0;
        drain();
    endtask

    // Monitor: every response pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            if (ack_s[k] || err_s[k]) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_resp inst=%0d cyc=%0d actual ack=%0b err=%0b required none",
                             k, cyc, ack_s[k], err_s[k]);
                end else begin
                    e = sb_q.pop_front();
                    $display("txn inst=%0d cyc=%0d ack=%0b err=%0b rdata=%h", k, cyc, ack_s[k], err_s[k], rdata_s[k]);
                    chk("resp_inst", k, k, e.inst);
                    chk("latency",   k, cyc, e.due);
                    chk("err",       k, {31'b0, err_s[k]}, {31'b0, e.err});
                    chk("ack",       k, {31'b0, ack_s[k]}, {31'b0, ~e.err});
                    chk("rdata",     k, rdata_s[k], e.rdata);
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 4; k++) begin
            rst_s[k] = 1'b1; req_s[k] = 1'b0; wr_s[k] = 1'b0; be_s[k] = 4'h0;
            addr_s[k] = 32'h0; wdata_s[k] = 32'h0;
        end

        // Vector table: inst, wr, be, addr, wdata, expected err, expected rdata
        add(1, 1, 4'b1111, 32'h0001_0010, 32'hDEAD_BEEF, 0, 32'h0);
        add(1, 0, 4'b1111, 32'h0001_0010, 32'h0,         0, 32'hDEAD_BEEF);
        add(1, 1, 4'b1111, 32'h0001_0020, 32'h1122_3344, 0, 32'h0);
        add(1, 1, 4'b1000, 32'h0001_0020, 32'hAA55_6677, 0, 32'h0);
        add(1, 0, 4'b0001, 32'h0001_0020, 32'h0,         0, 32'hAA22_3344);
        add(1, 1, 4'b1111, 32'h0001_0FFC, 32'hCAFE_F00D, 0, 32'h0);
        add(1, 0, 4'b1111, 32'h0000_FFFC, 32'h0,         1, 32'h0);
        add(1, 0, 4'b1111, 32'h0001_1000, 32'h0,         1, 32'h0);
        add(1, 0, 4'b1111, 32'hFFFF_FFFC, 32'h0,         1, 32'h0);
        add(1, 1, 4'b1111, 32'h0001_1000, 32'h1234_5678, 1, 32'h0);
        add(1, 0, 4'b1111, 32'h0001_0FFC, 32'h0,         0, 32'hCAFE_F00D);
        add(1, 1, 4'b0000, 32'h0001_0010, 32'h1234_5678, 1, 32'h0);
        add(1, 0, 4'b0000, 32'h0001_0010, 32'h0,         1, 32'h0);
        add(1, 0, 4'b1111, 32'h0001_0010, 32'h0,         0, 32'hDEAD_BEEF);
        add(1, 1, 4'b1111, 32'h0001_0030, 32'h0000_0000, 0, 32'h0);
        add(1, 1, 4'b0110, 32'h0001_0030, 32'hFFFF_FFFF, BE_CHK, 32'h0);
        add(1, 0, 4'b1111, 32'h0001_0030, 32'h0,         0, BE_CHK ? 32'h0 : 32'h00FF_FF00);
        add(1, 1, 4'b1111, 32'h0001_0000, 32'h0102_0304, 0, 32'h0);
        add(1, 0, 4'b1111, 32'h0001_0000, 32'h0,         0, 32'h0102_0304);
        add(0, 1, 4'b1111, 32'h0001_0100, 32'hA5A5_0001, 0, 32'h0);
        add(0, 0, 4'b1111, 32'h0001_0100, 32'h0,         0, 32'hA5A5_0001);
        add(0, 0, 4'b1111, 32'h0001_1000, 32'h0,         1, 32'h0);
        add(2, 1, 4'b1111, 32'h0001_0100, 32'h0000_BEEF, 0, 32'h0);
        add(2, 0, 4'b1111, 32'h0001_0100, 32'h0,         0, 32'h0000_BEEF);
        add(3, 1, 4'b1111, 32'h0001_0040, 32'h0F0F_0F0F, 0, 32'h0);
        add(3, 0, 4'b1111, 32'h0001_0040, 32'h0,         0, 32'h0F0F_0F0F);

        // Reset state
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("reset_ack",   k, {31'b0, ack_s[k]}, 32'h0);
            chk("reset_err",   k, {31'b0, err_s[k]}, 32'h0);
            chk("reset_rdata", k, rdata_s[k], 32'h0);
        end
        for (int k = 0; k < 4; k++) rst_s[k] = 1'b0;

        for (int i = 0; i < nv; i++) do_access(vecs[i]);

        // Back-to-back with zero wait states: requests in T, T+1 and T+2
        // produce acks in T+1, T+2 and T+3.
        @(negedge clk); issue(0, 1, 4'b1111, 32'h0001_0200, 32'h1111_1111, 0, 32'h0, 1'b1);
        @(negedge clk); issue(0, 1, 4'b1111, 32'h0001_0204, 32'h2222_2222, 0, 32'h0, 1'b1);
        @(negedge clk); issue(0, 0, 4'b1111, 32'h0001_0200, 32'h0,         0, 32'h1111_1111, 1'b1);
        @(negedge clk); req_s[0] = 1'b0;
        drain();
        do_access('{inst: 0, wr: 0, be: 4'b1111, addr: 32'h0001_0204, wdata: 32'h0, err: 0, rdata: 32'h2222_2222});

        // With two wait states, a request in T+1 arrives while BUSY and is
        // dropped. Its write must never happen.
        @(negedge clk); issue(2, 0, 4'b1111, 32'h0001_0100, 32'h0,         0, 32'h0000_BEEF, 1'b1);
        @(negedge clk); issue(2, 1, 4'b1111, 32'h0001_0100, 32'hBAD0_BAD0, 0, 32'h0, 1'b0);
        @(negedge clk); req_s[2] = 1'b0;
        drain();
        repeat (6) @(negedge clk);
        do_access('{inst: 2, wr: 0, be: 4'b1111, addr: 32'h0001_0100, wdata: 32'h0, err: 0, rdata: 32'h0000_BEEF});

        // Reset in the middle of a three-wait-state write. The write is
        // abandoned and no response is produced.
        @(negedge clk); issue(3, 1, 4'b1111, 32'h0001_0040, 32'h5555_5555, 0, 32'h0, 1'b0);
        @(negedge clk); req_s[3] = 1'b0;
        @(negedge clk); rst_s[3] = 1'b1;
        #1;
        chk("midreset_ack",   3, {31'b0, ack_s[3]}, 32'h0);
        chk("midreset_err",   3, {31'b0, err_s[3]}, 32'h0);
        chk("midreset_rdata", 3, rdata_s[3], 32'h0);
        @(negedge clk); rst_s[3] = 1'b0;
        repeat (8) @(negedge clk);
        do_access('{inst: 3, wr: 0, be: 4'b1111, addr: 32'h0001_0040, wdata: 32'h0, err: 0, rdata: 32'h0F0F_0F0F});

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32_mod_data_sram.md
Name: rv32_mod_data_sram

Overview:
Single-port, word-organised data memory slave that terminates the hart's external data bus (dext_*) driven by the load/store unit.
- Accepts one request at a time.
- Applies byte enables on writes and returns full aligned words on reads; the LSU extracts lanes and sign-extends.
- Inserts a configurable number of wait states.
- Signals a bus error for out-of-range or malformed accesses.
- Sits directly downstream of the LSU, in place of, or behind, a future data interconnect.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; power of two, >= 2.
BASE_ADDR, 32'h0001_0000, byte address of word 0; aligned to DEPTH_WORDS*4.
WAIT_STATES, 1, extra cycles between accept and response; 0..15.

Ports:
clk  input  1  clock.
reset  input  1  asynchronous, active-high reset.
req  input  1  request strobe (one-cycle pulse from LSU).
wr  input  1  1 = write, 0 = read; sampled with req.
be  input  4  byte enables, bit n = byte lane n (data[8n+7:8n]).
addr  input  32  byte address; addr[1:0] ignored (LSU sends word-aligned).
wdata  input  32  write data, all lanes; only enabled lanes stored.
rdata  output  32  read word; valid only while ack=1 on a read, else 0.
ack  output  1  one-cycle completion pulse.
err  output  1  one-cycle error pulse; mutually exclusive with ack.

Behaviour:
- Reset values: ack=0, err=0, rdata=0, FSM=IDLE, wait counter=0. Memory array is not cleared.
- Reset mid-operation:
  - An in-flight access is abandoned.
  - A write that has not yet reached its commit edge never modifies memory.
  - No ack or err is produced for the abandoned access.
- FSM states: IDLE and BUSY.
- IDLE:
  - req=1 at rising edge E0 latches wr, be, addr, wdata. This is the accept edge.
  - WAIT_STATES=0: the access commits at E0, and ack/err is high in the cycle after E0.
  - WAIT_STATES>0: go to BUSY with counter=WAIT_STATES-1.
- BUSY:
  - req is ignored: no latch, no queue, no response.
  - Counter decrements each edge.
  - At the edge where counter==0, the access commits, ack/err is registered high, and the FSM returns to IDLE.
- Latency: ack/err is high exactly in cycle T+1+WAIT_STATES, where T is the cycle req was sampled high.
  - ack/err stays high for exactly one cycle, then returns to 0.
- Back-to-back: the FSM is IDLE in the cycle ack/err is high, so a req sampled in that cycle is accepted. Maximum throughput is one access per WAIT_STATES+1 cycles.
- Range check: index = (addr - BASE_ADDR) >> 2.
  - Error if addr < BASE_ADDR or addr >= BASE_ADDR + DEPTH_WORDS*4. Unsigned 32-bit compare, no wrap-around; addr = 32'hFFFF_FFFC with default params is an error.
  - Error if be == 4'b0000.
- On error:
  - err=1, ack=0, rdata=0.
  - Memory is unchanged.
  - Timing is identical to a successful access.
- Write commit: mem[index] lane n <= wdata lane n for each be[n]=1; other lanes are unchanged. rdata=0 during a write ack.
- Read commit: rdata <= mem[index], the full word regardless of be. Registered, so it is valid in the ack cycle.
- Read of a never-written word returns X in simulation; the bench must write before reading.
- All outputs are registered; there are no combinational input-to-output paths.

Optional Feature:
Macro: RV32_DSRAM_BE_CHECK_EN.
- Defined: be must be one of 0001, 0010, 0100, 1000, 0011, 1100, 1111. Any other nonzero pattern (for example 0110 or 0101) produces err with normal timing and no memory update.
- Undefined: any nonzero be is accepted and masked per lane as above.

Test Plan:
1. Default params: write addr=32'h0001_0010, be=1111, wdata=32'hDEAD_BEEF, then read the same address -> each ack arrives in cycle T+2 after its req; read rdata=32'hDEAD_BEEF, err=0.
2. Byte-lane merge: write 32'h1122_3344/1111, then write 32'hAAxx_xxxx/1000 to the same word, then read -> rdata=32'hAA22_3344.
3. Out of range: read addr=32'h0000_FFFC and addr=32'h0001_1000 (DEPTH 1024) -> err=1, ack=0, rdata=0 in cycle T+2. A subsequent read of 32'h0001_0FFC returns the previously written value.
4. Back-to-back with WAIT_STATES=0: req in consecutive cycles T, T+1, T+2 -> ack in T+1, T+2, T+3. With WAIT_STATES=2, a req at T+1 (while BUSY) is ignored and only one ack appears, at T+3.
5. Reset mid-op: WAIT_STATES=3, issue a write of 32'h5555_5555 over a known 32'h0F0F_0F0F, assert reset in cycle T+2 -> no ack/err. After reset, a read returns 32'h0F0F_0F0F.
6. be=0000 -> err. With RV32_DSRAM_BE_CHECK_EN defined, be=0110 -> err and memory unchanged. Without the macro, be=0110 writes only lanes 1 and 2.
